// File: rtl/mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// mp_add_sequencer
//   Multi-precision add sequencer wrapped around an external carry-skip adder
//   (cs_adder). Operand word pairs arrive as a valid/ready packet stream,
//   least-significant word first. The block runs them through a two-stage
//   pipeline, chains the carry from word to word and returns the sum words on a
//   valid/ready stream. A WIDTH-bit adder can therefore perform N*WIDTH-bit
//   additions at one word per cycle.
//
//   Pipeline
//     S1 (operand stage) : registered a/b/first/last/cin; a and b drive the adder.
//     S2 (output stage)  : registered adder result, last flag and packet carry-out.
//
// Ports
//   Clk_i, Reset_ni        clock, asynchronous active-low reset
//   Clear_i                synchronous flush of pipeline, packet state and error flag
//   In_valid_i/In_ready_o  input handshake
//   In_a_i, In_b_i         operand words
//   In_first_i, In_last_i  packet delimiters
//   In_carry_i             packet carry-in, used only with the first word
//   Add_a_o, Add_b_o       operands to the adder
//   Add_c_o                carry-in to the adder
//   Add_sum_i, Add_carry_i result from the adder
//   Out_valid_o/Out_ready_i output handshake
//   Out_sum_o, Out_last_o  result word and last flag
//   Out_carry_o            packet carry-out, non-zero only on the last word
//   Busy_o                 packet open or pipeline holds data
//   Err_o                  sticky protocol-error flag
// -----------------------------------------------------------------------------
module mp_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             Reset_ni,
    input  logic             Clear_i,
    input  logic             In_valid_i,
    output logic             In_ready_o,
    input  logic [WIDTH-1:0] In_a_i,
    input  logic [WIDTH-1:0] In_b_i,
    input  logic             In_first_i,
    input  logic             In_last_i,
    input  logic             In_carry_i,
    output logic [WIDTH-1:0] Add_a_o,
    output logic [WIDTH-1:0] Add_b_o,
    output logic             Add_c_o,
    input  logic [WIDTH-1:0] Add_sum_i,
    input  logic             Add_carry_i,
    output logic             Out_valid_o,
    input  logic             Out_ready_i,
    output logic [WIDTH-1:0] Out_sum_o,
    output logic             Out_last_o,
    output logic             Out_carry_o,
    output logic             Busy_o,
    output logic             Err_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    // S1 operand stage
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_cin_q, s1_cin_d;

    // S2 output stage
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_carry_q, out_carry_d;

    // carry chain, packet state, error flag
    logic             carry_q, carry_d;
    logic [0:0]       state_q, state_d;
    logic             err_q, err_d;

    // handshake helpers
    logic             s2_load;
    logic             in_fire;
    logic             proto_err;

    // Advance and accept conditions of the two-stage pipeline.
    always_comb begin
        s2_load    = s1_valid_q & (~out_valid_q | Out_ready_i);
        In_ready_o = ~s1_valid_q | s2_load;
        in_fire    = In_valid_i & In_ready_o;
        // A word without first while idle, or a first inside an open packet.
        if (state_q == ST_IDLE) begin
            proto_err = in_fire & ~In_first_i;
        end else begin
            proto_err = in_fire & In_first_i;
        end
    end

    // Next-state logic for all pipeline, packet and error registers.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_cin_d    = s1_cin_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        carry_d     = carry_q;
        state_d     = state_q;
        err_d       = err_q;

        if (Clear_i) begin
            // Flush wins over any handshake; the word on In_* is dropped.
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            carry_d     = 1'b0;
            state_d     = ST_IDLE;
            err_d       = 1'b0;
        end else begin
            // S1 load / drain
            if (in_fire) begin
                s1_valid_d = 1'b1;
                s1_a_d     = In_a_i;
                s1_b_d     = In_b_i;
                // A word arriving while idle always opens a packet, so it
                // takes its carry-in from In_carry_i even without first.
                s1_first_d = In_first_i | (state_q == ST_IDLE);
                s1_last_d  = In_last_i;
                s1_cin_d   = In_carry_i;
                state_d    = In_last_i ? ST_IDLE : ST_IN_PKT;
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end

            // S2 load / drain; the carry register tracks the word just summed.
            if (s2_load) begin
                out_valid_d = 1'b1;
                out_sum_d   = Add_sum_i;
                out_last_d  = s1_last_q;
                out_carry_d = Add_carry_i & s1_last_q;
                carry_d     = Add_carry_i;
            end else if (Out_ready_i) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end

            if (proto_err) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_cin_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            carry_q     <= 1'b0;
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_cin_q    <= s1_cin_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            carry_q     <= carry_d;
            state_q     <= state_d;
            err_q       <= err_d;
        end
    end

    // Output drive: adder operands straight from S1 flops, carry muxed.
    always_comb begin
        Add_a_o     = s1_a_q;
        Add_b_o     = s1_b_q;
        Add_c_o     = s1_first_q ? s1_cin_q : carry_q;
        Out_valid_o = out_valid_q;
        Out_sum_o   = out_sum_q;
        Out_last_o  = out_last_q;
        Out_carry_o = out_carry_q;
        Busy_o      = (state_q == ST_IN_PKT) | s1_valid_q | out_valid_q;
        Err_o       = err_q;
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mp_add_sequencer
//   Directed bench for mp_add_sequencer with WIDTH=32. A behavioural adder
//   closes the Add_* loop. A monitor records every accepted output word; each
//   scenario task drives stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        in_valid, in_first, in_last, in_carry;
    logic [31:0] in_a, in_b;
    logic        in_ready;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_c, add_carry;
    logic        out_valid, out_ready, out_last, out_carry, busy, err;
    logic [31:0] out_sum;

    logic        fixed_ready, rnd_en, rnd_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_sum[$];
    logic        q_last[$];
    logic        q_carry[$];

    always #5 clk = ~clk;

    // behavioural model of cs_adder
    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c};
    assign out_ready = rnd_en ? rnd_ready : fixed_ready;

    mp_add_sequencer #(.WIDTH(32)) dut (
        .Clk_i(clk), .Reset_ni(rst_n), .Clear_i(clear),
        .In_valid_i(in_valid), .In_ready_o(in_ready),
        .In_a_i(in_a), .In_b_i(in_b),
        .In_first_i(in_first), .In_last_i(in_last), .In_carry_i(in_carry),
        .Add_a_o(add_a), .Add_b_o(add_b), .Add_c_o(add_c),
        .Add_sum_i(add_sum), .Add_carry_i(add_carry),
        .Out_valid_o(out_valid), .Out_ready_i(out_ready),
        .Out_sum_o(out_sum), .Out_last_o(out_last), .Out_carry_o(out_carry),
        .Busy_o(busy), .Err_o(err)
    );

    always begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            q_sum.push_back(out_sum);
            q_last.push_back(out_last);
            q_carry.push_back(out_carry);
        end
    end

    task automatic flush_q();
        q_sum.delete();
        q_last.delete();
        q_carry.delete();
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                             input logic first, input logic last, input logic cin,
                             output bit timed_out);
        in_a = a; in_b = b; in_first = first; in_last = last; in_carry = cin;
        in_valid = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (q_sum.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        in_last = 1'b0; in_carry = 1'b0; in_a = 32'd0; in_b = 32'd0;
        fixed_ready = 1'b1; rnd_en = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_sum !== 32'd0) begin bad++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        total++; if ({out_last, out_carry} !== 2'b00) begin bad++; $display("FAIL reset_last_carry got=%b exp=00", {out_last, out_carry}); end
        total++; if ({add_a, add_b, add_c} !== 65'd0) begin bad++; $display("FAIL reset_add got=%h exp=0", {add_a, add_b, add_c}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b exp=00", {busy, err}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_single();
        bit to;
        flush_q();
        send_word(32'd15, 32'd25, 1'b1, 1'b1, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL single_accept timed out"); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency1 got=%b exp=0", out_valid); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency2 got=%b exp=1", out_valid); end
        total++; if (out_sum !== 32'd40) begin bad++; $display("FAIL single_sum got=%0d exp=40", out_sum); end
        total++; if ({out_last, out_carry} !== 2'b10) begin bad++; $display("FAIL single_last_carry got=%b exp=10", {out_last, out_carry}); end
        cycles(2);
        flush_q();
    endtask

    task automatic test_two_words();
        bit to;
        flush_q();
        send_word(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, to);
        send_word(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, to);
        wait_outputs(2, to);
        total++; if (to) begin bad++; $display("FAIL two_words timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd0 || q_sum[1] !== 32'd1) begin bad++; $display("FAIL two_words_sum got=%h,%h exp=00000000,00000001", q_sum[0], q_sum[1]); end
            total++; if ({q_last[0], q_last[1], q_carry[0], q_carry[1]} !== 4'b0100) begin bad++; $display("FAIL two_words_flags got=%b exp=0100", {q_last[0], q_last[1], q_carry[0], q_carry[1]}); end
        end
        cycles(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL two_words_busy got=%b exp=0", busy); end
        flush_q();
    endtask

    task automatic test_carry_out();
        bit to;
        flush_q();
        send_word(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1, to);
        send_word(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, to);
        wait_outputs(2, to);
        total++; if (to) begin bad++; $display("FAIL carry_out timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd0 || q_sum[1] !== 32'd0) begin bad++; $display("FAIL carry_out_sum got=%h,%h exp=0,0", q_sum[0], q_sum[1]); end
            total++; if ({q_carry[0], q_carry[1]} !== 2'b01) begin bad++; $display("FAIL carry_out_flag got=%b exp=01", {q_carry[0], q_carry[1]}); end
        end
        cycles(1);
        flush_q();
    endtask

    task automatic test_backpressure();
        bit to;
        flush_q();
        fixed_ready = 1'b0;
        send_word(32'd1, 32'd1, 1'b1, 1'b1, 1'b0, to);
        send_word(32'd2, 32'd2, 1'b1, 1'b1, 1'b0, to);
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_sum !== 32'd2) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/2", i, out_valid, out_sum); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            cycles(1);
        end
        fixed_ready = 1'b1;
        wait_outputs(2, to);
        total++; if (to) begin bad++; $display("FAIL bp_drain timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd2 || q_sum[1] !== 32'd4) begin bad++; $display("FAIL bp_order got=%0d,%0d exp=2,4", q_sum[0], q_sum[1]); end
        end
        cycles(1);
        flush_q();
    endtask

    task automatic test_random();
        bit to;
        logic [127:0] a_full, b_full;
        logic [128:0] s_full;
        logic         cin;
        logic [31:0]  exp_sum[16];
        logic         exp_carry[4];
        flush_q();
        rnd_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int w = 0; w < 4; w++) begin
                a_full[32*w +: 32] = $urandom();
                b_full[32*w +: 32] = $urandom();
            end
            cin = 1'($urandom_range(0, 1));
            if (p == 0) begin
                a_full = {128{1'b1}};
                b_full = 128'd0;
                cin    = 1'b1;
            end
            s_full = {1'b0, a_full} + {1'b0, b_full} + {128'd0, cin};
            for (int w = 0; w < 4; w++) exp_sum[4*p + w] = s_full[32*w +: 32];
            exp_carry[p] = s_full[128];
            for (int w = 0; w < 4; w++) begin
                send_word(a_full[32*w +: 32], b_full[32*w +: 32], (w == 0), (w == 3), cin, to);
                total++; if (to) begin bad++; $display("FAIL rnd_accept p=%0d w=%0d timed out", p, w); end
            end
        end
        wait_outputs(16, to);
        rnd_en = 1'b0;
        total++; if (to) begin bad++; $display("FAIL rnd_drain got=%0d words exp=16", q_sum.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                total++; if (q_sum[i] !== exp_sum[i]) begin bad++; $display("FAIL rnd_sum i=%0d got=%h exp=%h", i, q_sum[i], exp_sum[i]); end
                total++; if (q_last[i] !== ((i % 4) == 3)) begin bad++; $display("FAIL rnd_last i=%0d got=%b", i, q_last[i]); end
                total++; if (q_carry[i] !== (((i % 4) == 3) ? exp_carry[i/4] : 1'b0)) begin bad++; $display("FAIL rnd_carry i=%0d got=%b", i, q_carry[i]); end
            end
        end
        cycles(5);
        total++; if (q_sum.size() != 16) begin bad++; $display("FAIL rnd_count got=%0d exp=16", q_sum.size()); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", err); end
        flush_q();
    endtask

    task automatic test_error();
        bit to;
        flush_q();
        send_word(32'd5, 32'd6, 1'b1, 1'b0, 1'b0, to);
        send_word(32'd7, 32'd8, 1'b1, 1'b1, 1'b1, to);
        wait_outputs(2, to);
        total++; if (to) begin bad++; $display("FAIL err_restart timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd11 || q_sum[1] !== 32'd16) begin bad++; $display("FAIL err_restart_sum got=%0d,%0d exp=11,16", q_sum[0], q_sum[1]); end
            total++; if ({q_last[0], q_last[1], q_carry[1]} !== 3'b010) begin bad++; $display("FAIL err_restart_flags got=%b exp=010", {q_last[0], q_last[1], q_carry[1]}); end
        end
        cycles(1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        flush_q();
        send_word(32'd9, 32'd9, 1'b1, 1'b0, 1'b0, to);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL err_busy_open got=%b exp=1", busy); end
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        total++; if ({err, busy, out_valid} !== 3'b000) begin bad++; $display("FAIL clear_state got=%b exp=000", {err, busy, out_valid}); end
        cycles(3);
        total++; if (q_sum.size() != 0) begin bad++; $display("FAIL clear_flush got=%0d words exp=0", q_sum.size()); end
        // word without first while idle: treated as first, uses In_carry_i
        send_word(32'd1, 32'd2, 1'b0, 1'b1, 1'b1, to);
        wait_outputs(1, to);
        total++; if (to) begin bad++; $display("FAIL nofirst timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd4 || q_last[0] !== 1'b1 || q_carry[0] !== 1'b0) begin bad++; $display("FAIL nofirst got=%0d/%b/%b exp=4/1/0", q_sum[0], q_last[0], q_carry[0]); end
        end
        cycles(1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nofirst_err got=%b exp=1", err); end
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        flush_q();
    endtask

    task automatic test_reset_mid();
        bit to;
        flush_q();
        send_word(32'd1, 32'd2, 1'b1, 1'b0, 1'b0, to);
        send_word(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, to);
        rst_n = 1'b0;
        #2;
        total++; if ({out_valid, out_last, out_carry, busy, err} !== 5'b00000) begin bad++; $display("FAIL rstmid_flags got=%b exp=00000", {out_valid, out_last, out_carry, busy, err}); end
        total++; if ({out_sum, add_a, add_b} !== 96'd0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", {out_sum, add_a, add_b}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(5);
        total++; if (q_sum.size() != 0) begin bad++; $display("FAIL rstmid_partial got=%0d words exp=0", q_sum.size()); end
        send_word(32'd3, 32'd4, 1'b1, 1'b1, 1'b0, to);
        wait_outputs(1, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_next timed out"); end
        else begin
            total++; if (q_sum[0] !== 32'd7 || q_last[0] !== 1'b1 || q_carry[0] !== 1'b0) begin bad++; $display("FAIL rstmid_next got=%0d/%b/%b exp=7/1/0", q_sum[0], q_last[0], q_carry[0]); end
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err); end
        cycles(2);
        flush_q();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_words();
        test_carry_out();
        test_backpressure();
        test_random();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
